// File: rtl/ram128x32_if.sv
// Bus bundle for the 128x32 single-port RAM: write enable, address and write data in, registered read data out.
interface ram128x32_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  Write_enable;
  logic [ADDR_WIDTH-1:0] Add;
  logic [DATA_WIDTH-1:0] Data;
  logic [DATA_WIDTH-1:0] Q;

  modport master (
    output Write_enable,
    output Add,
    output Data,
    input  Q
  );

  modport slave (
    input  Write_enable,
    input  Add,
    input  Data,
    output Q
  );
endinterface

// File: rtl/ram128x32.sv
// Single-port synchronous RAM, 128 x 32, write-first with a registered read port.
// Out-of-range addresses discard writes and read back as zero.
module ram128x32 #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128
) (
  input  logic        Clk,
  input  logic        Rst_n,
  ram128x32_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;

  // Only the low address bits index the array; the range check stops aliasing of high addresses.
  assign w_in_range = (32'(bus.Add) < 32'(DEPTH));
  assign w_idx      = bus.Add[IDX_W-1:0];

  // Storage and read register: reset clears every location and Q in a single edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_q <= '0;
    end else if (w_in_range) begin
      if (bus.Write_enable) begin
        r_mem[w_idx] <= bus.Data;
        r_q          <= bus.Data;
      end else begin
        r_q <= r_mem[w_idx];
      end
    end else begin
      r_q <= '0;
    end
  end

  assign bus.Q = r_q;
endmodule

// File: tb/tb_ram128x32.sv
// Scoreboard bench for ram128x32: directed scenarios followed by random traffic against an array model.
module tb_ram128x32;
  typedef struct {
    int          id;
    logic [31:0] exp;
  } exp_t;

  logic Clk;
  logic Rst_n;

  ram128x32_if bus ();

  ram128x32 dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t        sb_q[$];
  logic [31:0] model_mem [128];
  int          checks = 0;
  int          errors = 0;
  int          op_id  = 0;

  // Issue one operation on the next rising edge, then record what the memory should present.
  task automatic do_op(input bit rst, input bit we, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    Rst_n            = ~rst;
    bus.Write_enable = we;
    bus.Add          = a;
    bus.Data         = d;
    @(posedge Clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
      e.exp = 32'h0;
    end else if (a >= 8'd128) begin
      e.exp = 32'h0;
    end else if (we) begin
      model_mem[a] = d;
      e.exp        = d;
    end else begin
      e.exp = model_mem[a];
    end
    e.id = op_id;
    op_id++;
    sb_q.push_back(e);
    Rst_n            = 1'b1;
    bus.Write_enable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    do_op(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    do_op(1'b0, 1'b0, a, 32'h0);
  endtask

  // Monitor: one expected entry per issued edge, compared half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.Q !== e.exp) begin
          errors++;
          $display("FAIL op%0d Q: got %h expected %h", e.id, bus.Q, e.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  ra;
    logic [31:0] rdat;
    Rst_n            = 1'b1;
    bus.Write_enable = 1'b0;
    bus.Add          = 8'h0;
    bus.Data         = 32'h0;
    repeat (2) @(posedge Clk);
    #1;

    do_op(1'b1, 1'b0, 8'd0, 32'h0);

    wr(8'd0,   32'd1);
    wr(8'd10,  32'd10);
    wr(8'd20,  32'd220);
    wr(8'd50,  32'd5550);
    wr(8'd100, 32'hFFAC0780);
    wr(8'd127, 32'hFFFFFFFF);

    rd(8'd0);  rd(8'd10);  rd(8'd20);
    rd(8'd50); rd(8'd100); rd(8'd127);

    rd(8'd5);
    wr(8'd10, 32'h12345678);
    rd(8'd10);

    wr(8'd72,  32'h0BADF00D);
    wr(8'd200, 32'hDEADBEEF);
    rd(8'd200);
    rd(8'd72);
    wr(8'd3, 32'h00000000);
    rd(8'd3);

    do_op(1'b1, 1'b1, 8'd9, 32'h55555555);
    rd(8'd0); rd(8'd100); rd(8'd127); rd(8'd9);

    wr(8'd1, 32'hA5A5A5A5);
    rd(8'd1);
    rd(8'd1);

    for (int n = 0; n < 400; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rdat = $urandom;
      if ($urandom_range(0, 63) == 0)
        do_op(1'b1, 1'($urandom_range(0, 1)), ra, rdat);
      else if ($urandom_range(0, 3) == 0)
        do_op(1'b0, 1'b1, {1'b0, ra[6:0]}, rdat);
      else
        do_op(1'b0, 1'($urandom_range(0, 1)), ra, rdat);
    end

    repeat (3) @(negedge Clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
